// File: rtl/add_sequencer.sv
// add_sequencer
//   Multi-cycle adder. One 4-bit ripple-carry nibble adder is shared across
//   all nibbles of the operands, least significant nibble first. An
//   accepted start latches the operands. Each following cycle then adds one
//   nibble. A one-cycle done pulse marks the point where sum and cout are
//   valid.
//
// Parameters
//   NIBBLES : operand width in 4-bit nibbles (1..8)
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, has priority over start
//   start : request an addition (accepted only in IDLE)
//   a, b  : operands, sampled when start is accepted
//   busy  : high whenever the sequencer is not IDLE
//   done  : one-cycle pulse, sum/cout valid
//   sum   : registered result, (a + b) mod 2^(4*NIBBLES)
//   cout  : registered carry out of the top bit
module add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic            r_cout;
  logic            r_busy;
  logic            r_done;
  logic [IDXW-1:0] r_idx;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [4:0]      w_nib_res;

  // The 4-bit ripple-carry nibble adder: {carry_out, sum[3:0]}.
  function automatic logic [4:0] nib_add(input logic [3:0] x,
                                         input logic [3:0] y,
                                         input logic       ci);
    return {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

  // Select the current nibble of each latched operand. An AND-OR mux keeps
  // every select constant, so no index can reach past the operand width.
  always_comb begin
    w_a_nib = 4'd0;
    w_b_nib = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      w_a_nib = w_a_nib | (r_a[4*i +: 4] & {4{r_idx == IDXW'(i)}});
      w_b_nib = w_b_nib | (r_b[4*i +: 4] & {4{r_idx == IDXW'(i)}});
    end
    w_nib_res = nib_add(w_a_nib, w_b_nib, r_carry);
  end

  // Sequencer FSM with all datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDXW'(i)) begin
              r_sum[4*i +: 4] <= w_nib_res[3:0];
            end
          end
          r_carry <= w_nib_res[4];
          if (r_idx == LAST_IDX) begin
            // Final nibble: publish the carry and wrap idx so it never
            // points past the top nibble.
            r_cout  <= w_nib_res[4];
            r_idx   <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + IDXW'(1);
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_add_sequencer.sv
// Directed testbench for add_sequencer. It uses a NIBBLES=4 instance for
// most vectors and a NIBBLES=1 instance for the single-nibble corner.
module tb_add_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  logic        start1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        busy1;
  logic        done1;
  logic [3:0]  sum1;
  logic        cout1;

  int errors;
  int checks;

  add_sequencer #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  add_sequencer #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start with the given operands on the 4-nibble DUT. Report the
  // edge offset of done (0 = never seen) and the count of busy cycles.
  task automatic op4(input logic [15:0] av, input logic [15:0] bv,
                     output int lat, output int busy_cyc, output int done_cnt);
    a = av;
    b = bv;
    start = 1'b1;
    tick();                      // edge k
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = i;
      end
      if (!busy) break;
      tick();
    end
  endtask

  int lat, bc, dc;

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = 16'h0000;
    b      = 16'h0000;
    start1 = 1'b0;
    a1     = 4'h0;
    b1     = 4'h0;
    tick();
    tick();

    // Reset state.
    chk_eq("rst_busy", busy, 1'b0);
    chk_eq("rst_done", done, 1'b0);
    chk_eq("rst_sum",  sum,  16'h0000);
    chk_eq("rst_cout", cout, 1'b0);
    chk_eq("rst_busy1", busy1, 1'b0);
    rst = 1'b0;

    // Basic add: done on edge k+4, busy for 5 cycles.
    op4(16'h1234, 16'h4321, lat, bc, dc);
    chk_eq("t1_lat",  lat, 4);
    chk_eq("t1_busy", bc,  5);
    chk_eq("t1_dcnt", dc,  1);
    chk_eq("t1_sum",  sum, 16'h5555);
    chk_eq("t1_cout", cout, 1'b0);
    // The result must hold while idle.
    tick(); tick(); tick();
    chk_eq("t1_hold_sum", sum, 16'h5555);
    chk_eq("t1_hold_done", done, 1'b0);

    // The carry ripples through every nibble.
    op4(16'hFFFF, 16'h0001, lat, bc, dc);
    chk_eq("t2_lat",  lat, 4);
    chk_eq("t2_sum",  sum, 16'h0000);
    chk_eq("t2_cout", cout, 1'b1);

    // Operands change during ADD, so the captured values must be used.
    a = 16'h0FF0;
    b = 16'h0110;
    start = 1'b1;
    tick();                      // edge k
    start = 1'b0;
    a = 16'hFFFF;
    b = 16'hFFFF;
    tick(); tick(); tick(); tick();  // edge k+4
    chk_eq("t3_done", done, 1'b1);
    chk_eq("t3_sum",  sum,  16'h1100);
    chk_eq("t3_cout", cout, 1'b0);
    tick();
    chk_eq("t3_idle", busy, 1'b0);

    // Start is held high for 10 cycles. The second start is accepted at k+6.
    a = 16'h8000;
    b = 16'h8000;
    start = 1'b1;
    tick();                      // edge k
    chk_eq("t4_busy_k", busy, 1'b1);
    tick();                      // k+1
    a = 16'h1111;                // these become the second operation's operands
    b = 16'h2222;
    tick(); tick(); tick();      // k+4
    chk_eq("t4_done1", done, 1'b1);
    chk_eq("t4_sum1",  sum,  16'h0000);
    chk_eq("t4_cout1", cout, 1'b1);
    tick();                      // k+5: DONE->IDLE, start ignored
    chk_eq("t4_idle_busy", busy, 1'b0);
    chk_eq("t4_idle_done", done, 1'b0);
    tick();                      // k+6: accepted
    chk_eq("t4_accept", busy, 1'b1);
    chk_eq("t4_sum_clr", sum, 16'h0000);
    chk_eq("t4_cout_clr", cout, 1'b0);
    tick(); tick(); tick();      // k+9
    chk_eq("t4_no_done_k9", done, 1'b0);
    start = 1'b0;
    tick();                      // k+10
    chk_eq("t4_done2", done, 1'b1);
    chk_eq("t4_sum2",  sum,  16'h3333);
    chk_eq("t4_cout2", cout, 1'b0);
    tick();                      // k+11
    chk_eq("t4_end_busy", busy, 1'b0);

    // Reset arrives mid-operation at edge k+2.
    a = 16'h7777;
    b = 16'h1111;
    start = 1'b1;
    tick();                      // k
    start = 1'b0;
    tick();                      // k+1: low nibble written (8)
    chk_eq("t5_partial", sum, 16'h0008);
    rst = 1'b1;
    tick();                      // k+2
    chk_eq("t5_busy", busy, 1'b0);
    chk_eq("t5_done", done, 1'b0);
    chk_eq("t5_sum",  sum,  16'h0000);
    chk_eq("t5_cout", cout, 1'b0);
    rst = 1'b0;
    // Start on the very first edge after reset is released.
    op4(16'h0001, 16'h0002, lat, bc, dc);
    chk_eq("t5_lat",  lat, 4);
    chk_eq("t5_dcnt", dc,  1);
    chk_eq("t5_sum2", sum, 16'h0003);
    chk_eq("t5_cout2", cout, 1'b0);

    // Single-nibble instance: done on edge k+1.
    a1 = 4'hF;
    b1 = 4'hF;
    start1 = 1'b1;
    tick();                      // k
    start1 = 1'b0;
    chk_eq("n1_busy_k", busy1, 1'b1);
    chk_eq("n1_done_k", done1, 1'b0);
    tick();                      // k+1
    chk_eq("n1_done", done1, 1'b1);
    chk_eq("n1_sum",  sum1,  4'hE);
    chk_eq("n1_cout", cout1, 1'b1);
    tick();                      // k+2
    chk_eq("n1_idle", busy1, 1'b0);
    chk_eq("n1_done_off", done1, 1'b0);
    chk_eq("n1_hold", sum1, 4'hE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
